// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for seg7_scan_driver: digit select, load path and display drive.
// master = upstream controller, slave = display driver.
interface seg7_scan_driver_if;
  logic [1:0]  sel;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output sel, data_in, dp_in, load,
    input  pending, an, seg, dp
  );

  modport slave (
    input  sel, data_in, dp_in, load,
    output pending, an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed common-anode 7-seg driver, frame-committed double buffer.
// SEG7_LZ_BLANK_EN: when defined, suppresses leading zeros on digits 3..1.
module seg7_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_driver_if.slave bus
);

  localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES);

  // {dp[3:0], hex[15:0]}
  logic [19:0] disp_reg;
  logic [19:0] disp_nxt;
  logic [19:0] pend_reg;
  logic        pend_flag;
  logic [1:0]  sel_q;
  logic [7:0]  blank_cnt;
  logic [7:0]  blank_nxt;
  logic        change;
  logic        boundary;
  logic [3:0]  nib;
  logic        lz;
  logic [3:0]  an_q;
  logic [3:0]  an_d;
  logic [6:0]  seg_q;
  logic [6:0]  seg_d;
  logic        dp_q;
  logic        dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    change   = bus.sel != sel_q;
    boundary = change && (sel_q == 2'd3) && (bus.sel == 2'd0);
    disp_nxt = (boundary && pend_flag) ? pend_reg : disp_reg;
  end

  always_comb begin
    blank_nxt = blank_cnt;
    if (change)
      blank_nxt = BLANK_INIT;
    else if (blank_cnt != 8'd0)
      blank_nxt = blank_cnt - 8'd1;
  end

  always_comb begin
    nib = disp_nxt[{bus.sel, 2'b00} +: 4];
`ifdef SEG7_LZ_BLANK_EN
    unique case (bus.sel)
      2'd3:    lz = disp_nxt[15:12] == 4'd0;
      2'd2:    lz = disp_nxt[15:8] == 8'd0;
      2'd1:    lz = disp_nxt[15:4] == 12'd0;
      default: lz = 1'b0;
    endcase
`else
    lz = 1'b0;
`endif
  end

  // Drive from the post-commit buffer so a held select never changes output.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (blank_nxt == 8'd0) begin
      an_d  = ~(4'b0001 << bus.sel);
      seg_d = lz ? 7'h7F : ~hex7(nib);
      dp_d  = ~disp_nxt[5'd16 + {3'd0, bus.sel}];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg  <= '0;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
      sel_q     <= 2'd0;
      blank_cnt <= 8'd0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      disp_reg  <= disp_nxt;
      sel_q     <= bus.sel;
      blank_cnt <= blank_nxt;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      if (bus.load) begin
        pend_reg  <= {bus.dp_in, bus.data_in};
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
    end
  end

  assign bus.pending = pend_flag;
  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed + random bench for seg7_scan_driver against a frame-level model.
// Honors SEG7_LZ_BLANK_EN the same way the design does.
module tb_seg7_scan_driver;

  localparam int N = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.BLANK_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16];

  // Model: displayed word, pending word, edges since the last select change.
  logic [15:0] m_disp;
  logic [3:0]  m_ddp;
  logic [15:0] m_pdat;
  logic [3:0]  m_pdp;
  logic        m_pending;
  logic [1:0]  m_prev;
  int          m_since;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_disp    = '0;
    m_ddp     = '0;
    m_pdat    = '0;
    m_pdp     = '0;
    m_pending = 1'b0;
    m_prev    = 2'd0;
    m_since   = 1000;
  endtask

  task automatic m_outputs(input logic [1:0] s);
    int sh;
    logic [15:0] upper;
    sh    = 4 * int'(s);
    upper = m_disp >> sh;
    if (m_since <= N) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = 4'hF & ~(4'h1 << s);
      e_seg = ~hex_tab[upper[3:0]];
`ifdef SEG7_LZ_BLANK_EN
      if (s != 2'd0 && upper == 16'd0) e_seg = 7'h7F;
`endif
      e_dp  = ~m_ddp[s];
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".an"},  32'(bus.an),      32'(e_an));
    chk({tag, ".seg"}, 32'(bus.seg),     32'(e_seg));
    chk({tag, ".dp"},  32'(bus.dp),      32'(e_dp));
    chk({tag, ".pnd"}, 32'(bus.pending), 32'(m_pending));
  endtask

  task automatic tick(input logic [1:0] s, input logic ld,
                      input logic [15:0] d, input logic [3:0] p);
    bus.sel     = s;
    bus.load    = ld;
    bus.data_in = d;
    bus.dp_in   = p;
    @(posedge clk);
    if (s != m_prev) m_since = 1;
    else if (m_since < 1000) m_since++;
    if (m_prev == 2'd3 && s == 2'd0 && m_pending) begin
      m_disp    = m_pdat;
      m_ddp     = m_pdp;
      m_pending = 1'b0;
    end
    if (ld) begin
      m_pdat    = d;
      m_pdp     = p;
      m_pending = 1'b1;
    end
    m_prev = s;
    m_outputs(s);
    #1;
    bus.load = 1'b0;
    check_all("step");
  endtask

  task automatic hold(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) tick(s, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    checks   = 0;
    failures = 0;
    rst         = 1'b1;
    bus.sel     = 2'd0;
    bus.load    = 1'b0;
    bus.data_in = 16'h0;
    bus.dp_in   = 4'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.an",  32'(bus.an),      32'hF);
    chk("rst.seg", 32'(bus.seg),     32'h7F);
    chk("rst.dp",  32'(bus.dp),      32'h1);
    chk("rst.pnd", 32'(bus.pending), 32'h0);
    #3 rst = 1'b0;

    hold(2'd0, 2);
    chk("idle.seg0", 32'(bus.seg), 32'h40);

    // commit at frame boundary
    tick(2'd0, 1'b1, 16'h1A3F, 4'b0010);
    tick(2'd1, 1'b0, 16'h0, 4'h0);
    chk("c.pnd1", 32'(bus.pending), 32'h1);
    tick(2'd2, 1'b0, 16'h0, 4'h0);
    tick(2'd3, 1'b0, 16'h0, 4'h0);
    chk("c.pnd3", 32'(bus.pending), 32'h1);
    tick(2'd0, 1'b0, 16'h0, 4'h0);
    chk("c.pnd0", 32'(bus.pending), 32'h0);
    hold(2'd0, 3);
    chk("c.blank4", 32'(bus.an), 32'hF);
    hold(2'd0, 1);
    chk("c.an0",  32'(bus.an),  32'hE);
    chk("c.seg0", 32'(bus.seg), 32'h0E);
    chk("c.dp0",  32'(bus.dp),  32'h1);
    hold(2'd1, 5);
    chk("c.an1",  32'(bus.an),  32'hD);
    chk("c.seg1", 32'(bus.seg), 32'h30);
    chk("c.dp1",  32'(bus.dp),  32'h0);

    // blank restart
    hold(2'd2, 2);
    tick(2'd3, 1'b0, 16'h0, 4'h0);
    hold(2'd3, 3);
    chk("b.still", 32'(bus.an), 32'hF);
    hold(2'd3, 1);
    chk("b.drive", 32'(bus.an), 32'h7);

    // load colliding with boundary
    tick(2'd3, 1'b1, 16'h0001, 4'h0);
    tick(2'd0, 1'b1, 16'h0002, 4'h0);
    chk("x.pnd", 32'(bus.pending), 32'h1);
    hold(2'd0, 4);
    chk("x.seg1", 32'(bus.seg), 32'h79);
    hold(2'd1, 1);
    hold(2'd2, 1);
    hold(2'd3, 1);
    hold(2'd0, 5);
    chk("x.seg2", 32'(bus.seg), 32'h24);
    chk("x.pnd2", 32'(bus.pending), 32'h0);

    // non-sequential jump
    hold(2'd2, 1);
    tick(2'd3, 1'b1, 16'h1234, 4'h5);
    tick(2'd1, 1'b0, 16'h0, 4'h0);
    hold(2'd1, 2);
    chk("j.pnd", 32'(bus.pending), 32'h1);
    hold(2'd0, 5);
    chk("j.seg", 32'(bus.seg), 32'h24);

    // leading zeros
    hold(2'd2, 1);
    tick(2'd3, 1'b1, 16'h0050, 4'h0);
    tick(2'd0, 1'b0, 16'h0, 4'h0);
    hold(2'd0, 5);
    chk("lz.d0", 32'(bus.seg), 32'h40);
    hold(2'd1, 5);
    chk("lz.d1", 32'(bus.seg), 32'h12);
    hold(2'd2, 5);
`ifdef SEG7_LZ_BLANK_EN
    chk("lz.d2", 32'(bus.seg), 32'h7F);
`else
    chk("lz.d2", 32'(bus.seg), 32'h40);
`endif
    chk("lz.an2", 32'(bus.an), 32'hB);

    // asynchronous reset mid-cycle
    tick(2'd3, 1'b1, 16'hBEEF, 4'h3);
    #2 rst = 1'b1;
    #1;
    chk("ar.an",  32'(bus.an),      32'hF);
    chk("ar.seg", 32'(bus.seg),     32'h7F);
    chk("ar.dp",  32'(bus.dp),      32'h1);
    chk("ar.pnd", 32'(bus.pending), 32'h0);
    m_reset();
    #2 rst = 1'b0;
    tick(2'd3, 1'b0, 16'h0, 4'h0);
    hold(2'd0, 5);
    chk("ar.seg0", 32'(bus.seg), 32'h40);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] s;
      r = int'($urandom_range(0, 9));
      if (r < 5) s = m_prev;
      else if (r < 8) s = m_prev + 2'd1;
      else s = 2'($urandom_range(0, 3));
      tick(s, ($urandom_range(0, 5) == 0), 16'($urandom),
           4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 2-bit digit-select counter. It takes the free-running `counter[1:0]` as its digit select.
- Drives a 4-digit multiplexed seven-segment display (common-anode, active-low) from a 16-bit hex value.
- New values are double-buffered and committed only at a frame boundary, so the display never tears mid-scan.
- An anti-ghosting blank window follows every digit change.

Parameters:
- BLANK_CYCLES, 4: clk cycles all anodes are held off after a digit-select change. Legal range 0..255; 0 means no blanking.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sel  input  2  digit select, driven by the upstream 2-bit counter
- data_in  input  16  hex value; digit3 = [15:12] ... digit0 = [3:0]
- dp_in  input  4  decimal points, one per digit, active-high
- load  input  1  single-cycle strobe; captures data_in and dp_in into the pending buffer
- pending  output  1  high while a captured value awaits its frame commit
- an  output  4  anodes, active-low; an[i] enables digit i
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
Reset (asynchronous, rst=1):
- disp_reg = 0, pend_reg = 0, pending = 0, sel_q = 0, blank_cnt = 0.
- an = 4'b1111, seg = 7'h7F, dp = 1.

Capture:
- load=1 at a clk edge: pend_reg <= {dp_in, data_in}, pending <= 1.
- load while pending=1 overwrites pend_reg; last load wins.

Change detect:
- sel_q <= sel every edge.
- A change is sel != sel_q at an edge.

Frame boundary:
- Defined as a change with sel_q=3 and sel=0.
- If pending=1 at the boundary: disp_reg <= pend_reg, pending <= 0.
- load and boundary on the same edge: the old pend_reg commits, the new value is stored in pend_reg, and pending stays 1.
- Non-sequential jumps (e.g. 3->1, 2->0) are not boundaries.

Blanking:
- On a change, blank_cnt <= BLANK_CYCLES; otherwise it decrements while nonzero.
- Outputs are registered. At an edge where the next blank_cnt is nonzero: an = 1111, seg = 7F, dp = 1.
- Otherwise: an = ~(1 << sel), seg = hex7(digit[sel] of disp_reg), dp = ~dp_bit[sel].
- With BLANK_CYCLES=0, the new digit drives 1 cycle after sel changes.
- With BLANK_CYCLES=N, the new digit drives after N blank cycles, on edge N+1 after the change.
- A change during an active blank window restarts the count.

Hex decode (active-high a..g before inversion):
- 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
- 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71

Hold:
- sel constant means outputs are constant.
- load alone never changes an/seg/dp until the next frame boundary.

Reset mid-operation:
- Outputs go to their reset values immediately, without waiting for clk.
- Pending data is discarded.
- After rst falls, the first detected change triggers blanking. A commit happens only after a new load and a 3->0 transition.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit i (i = 3..1) shows seg = 7F while its nibble and all higher nibbles of disp_reg are 0. Its anode is still driven and its dp is still honoured. Digit 0 is always shown.
- Not defined: all four digits are always decoded, including leading zeros.

Test Plan:
- Reset check: assert rst mid-cycle with BLANK_CYCLES=4 -> an=1111, seg=7F, dp=1, pending=0 immediately, with no clk edge.
- Commit at boundary: load data_in=16'h1A3F, dp_in=0010, then step sel 0->1->2->3->0 -> pending=1 until the 3->0 edge, then 0. After blanking with sel=0: an=1110, seg=~71=0E, dp=1. With sel=1: an=1101, seg=~4F=30, dp=0.
- Blank window: BLANK_CYCLES=4, change sel 0->1 -> an=1111 on edges 1-4, an=1101 on edge 5. Change sel again at edge 2 -> the 4-cycle count restarts.
- Commit/load collision: load 16'h0001; later load 16'h0002 on the same edge as 3->0 -> digit0 shows 1 and pending stays 1. The next 3->0 shows 2.
- Non-boundary jump: pending=1, sel 3->1 -> no commit, pending stays 1.
- Leading zeros: data 16'h0050. With SEG7_LZ_BLANK_EN: digits 3 and 2 give seg=7F, digit1 gives seg=12, digit0 gives seg=40. Without the macro: digits 3 and 2 give seg=40.
